// File: rtl/cia_pkg.sv
// Shared types and constants for the CIA register-bus blocks.
package cia;
  typedef logic [3:0] reg4_t;
  typedef logic [7:0] reg8_t;

  typedef enum logic [2:0] {RESET, IDLE, ARMED, PH1, PH2} bm_state_t;

  localparam reg4_t ICR_ADDR = 4'hD;
endpackage

// File: rtl/cia_phi2_gen.sv
// Free-running phi2 generator: PHI2_DIV clks per half-period, plus edge strobes.
module cia_phi2_gen #(
  parameter int PHI2_DIV = 12
) (
  input  logic clk,
  input  logic rst_n,
  output logic phi2,
  output logic rise_ev,
  output logic fall_ev,
  output logic last_clk
);
  localparam int CW = (PHI2_DIV > 2) ? $clog2(PHI2_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHI2_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      phi2 <= 1'b0;
    end else if (last_clk) begin
      cnt  <= '0;
      phi2 <= ~phi2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Strobes mark the clk on whose rising edge phi2 is about to toggle.
  assign last_clk = (cnt == LAST);
  assign rise_ev  = last_clk & ~phi2;
  assign fall_ev  = last_clk & phi2;
endmodule

// File: rtl/cia_bus_master.sv
// Host-side CIA bus initiator: turns valid/ready requests into phi2-aligned bus cycles.
// Optional sticky interrupt output enabled with `define CIA_BUS_MASTER_IRQ_EN.
module cia_bus_master
  import cia::*;
#(
  parameter int PHI2_DIV   = 12,
  parameter int RES_CYCLES = 10
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req_valid,
  output logic  req_ready,
  input  logic  req_reset,
  input  logic  req_we,
  input  reg4_t req_addr,
  input  reg8_t req_wdata,
  output logic  rsp_valid,
  output reg8_t rsp_rdata,
  output logic  phi2,
  output logic  cia_res_n,
  output logic  cs_n,
  output logic  r_w_n,
  output reg4_t addr,
  output reg8_t data_o,
  output logic  data_oe,
  input  reg8_t data_i,
  input  logic  irq_n,
  output logic  irq
);
  localparam int RW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
  localparam logic [RW-1:0] RES_LAST = RW'(RES_CYCLES - 1);

  // Handshake: a request transfers on a clk edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so req_* are ignored everywhere else.
  bm_state_t     state;
  logic [RW-1:0] res_cnt;
  logic          from_req;
  logic          we_q;
  reg4_t         addr_q;
  reg8_t         wdata_q;
  logic          rise_ev, fall_ev, last_clk;

  cia_phi2_gen #(.PHI2_DIV(PHI2_DIV)) u_phi2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .phi2     (phi2),
    .rise_ev  (rise_ev),
    .fall_ev  (fall_ev),
    .last_clk (last_clk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RESET;
      res_cnt   <= '0;
      from_req  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cia_res_n <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      cs_n      <= 1'b1;
      r_w_n     <= 1'b1;
      addr      <= '0;
      data_o    <= '0;
      data_oe   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        RESET: begin
          if (fall_ev) begin
            if (res_cnt == RES_LAST) begin
              state     <= IDLE;
              cia_res_n <= 1'b1;
              req_ready <= 1'b1;
              rsp_valid <= from_req;
              from_req  <= 1'b0;
              res_cnt   <= '0;
            end else begin
              res_cnt <= res_cnt + 1'b1;
            end
          end
        end
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_reset) begin
              state     <= RESET;
              cia_res_n <= 1'b0;
              from_req  <= 1'b1;
              res_cnt   <= '0;
            end else begin
              state   <= ARMED;
              we_q    <= req_we;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
            end
          end
        end
        ARMED: begin
          if (fall_ev) begin
            state <= PH1;
            cs_n  <= 1'b0;
            r_w_n <= ~we_q;
            addr  <= addr_q;
          end
        end
        PH1: begin
          if (rise_ev) begin
            state   <= PH2;
            data_oe <= we_q;
            data_o  <= wdata_q;
          end
        end
        PH2: begin
          // Read data is taken on the last clk of phi2 high, as late as the bus allows.
          if (last_clk && !we_q) rsp_rdata <= data_i;
          if (fall_ev) begin
            state     <= IDLE;
            cs_n      <= 1'b1;
            r_w_n     <= 1'b1;
            data_oe   <= 1'b0;
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        default: state <= RESET;
      endcase
    end
  end

`ifdef CIA_BUS_MASTER_IRQ_EN
  logic [2:0] irq_sync;
  logic       irq_clr;

  assign irq_clr = (state == PH2) && fall_ev && !we_q && (addr_q == ICR_ADDR);

  // Two synchronizer flops plus one history flop for falling-edge detection; set beats clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_sync <= 3'b111;
      irq      <= 1'b0;
    end else begin
      irq_sync <= {irq_sync[1:0], irq_n};
      if (irq_sync[2] && !irq_sync[1]) irq <= 1'b1;
      else if (irq_clr)                irq <= 1'b0;
    end
  end
`else
  logic unused_irq_n;
  assign unused_irq_n = irq_n;
  assign irq          = 1'b0;
`endif
endmodule

// File: tb/tb_cia_bus_master.sv
// Self-checking bench for cia_bus_master: driver tasks, bus monitor and response scoreboard.
module tb_cia_bus_master;
  localparam int PHI2_DIV   = 12;
  localparam int RES_CYCLES = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_reset = 1'b0, req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, phi2, cia_res_n, cs_n, r_w_n, data_oe, irq;
  logic [7:0] rsp_rdata, data_o;
  logic [3:0] addr;
  logic [7:0] data_i = '0;
  logic       irq_n = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] model_rdata = '0;
  logic [3:0] cur_addr = '0;
  logic       cur_we = 1'b0;
  logic [7:0] cur_wdata = '0;
  bit         b2b = 1'b0;

  cia_bus_master #(.PHI2_DIV(PHI2_DIV), .RES_CYCLES(RES_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_reset(req_reset),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .phi2(phi2), .cia_res_n(cia_res_n), .cs_n(cs_n), .r_w_n(r_w_n),
    .addr(addr), .data_o(data_o), .data_oe(data_oe), .data_i(data_i),
    .irq_n(irq_n), .irq(irq)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- bus monitor + scoreboard ----------------
  int   t = 0, cs_run = 0, oe_run = 0, hi_cnt = 0, last_rise_t = 0;
  logic prev_cs = 1'b1, prev_phi2 = 1'b0, prev_rsp = 1'b0;

  always @(negedge clk) begin
    t++;
    if (!rst_n) begin
      cs_run = 0; oe_run = 0; hi_cnt = 0;
      prev_cs = 1'b1; prev_rsp = 1'b0; data_i = 8'h00;
    end else begin
      hi_cnt = phi2 ? hi_cnt + 1 : 0;
      // Valid read data only on the final clk of phi2 high.
      if (!cs_n && r_w_n && phi2 && hi_cnt == PHI2_DIV && rd_q.size() > 0)
        data_i = rd_q.pop_front();
      else
        data_i = 8'h00;

      if (!cs_n) begin
        if (prev_cs) begin
          check("cs_start_on_phi2_fall", {prev_phi2, phi2}, 2'b10);
          if (b2b && last_rise_t > 0) check("b2b_gap", t - last_rise_t, 2 * PHI2_DIV);
        end
        cs_run++;
        check("addr", addr, cur_addr);
        check("r_w_n", r_w_n, !cur_we);
        if (r_w_n) check("read_data_oe", data_oe, 1'b0);
      end else if (!prev_cs) begin
        check("cs_len", cs_run, 2 * PHI2_DIV);
        cs_run = 0;
        last_rise_t = t;
      end

      if (data_oe) begin
        oe_run++;
        check("oe_in_phi2_high", phi2, 1'b1);
        check("data_o", data_o, cur_wdata);
      end else if (oe_run > 0) begin
        check("oe_len", oe_run, PHI2_DIV);
        oe_run = 0;
      end

      if (rsp_valid) begin
        check("rsp_one_clk", prev_rsp, 1'b0);
        if (exp_q.size() == 0) check("rsp_unexpected", exp_q.size(), 1);
        else                   check("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
      prev_cs  = cs_n;
      prev_rsp = rsp_valid;
    end
    prev_phi2 = phi2;
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic rs, input logic we, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] rd);
    int n = 0;
    req_valid = 1'b1; req_reset = rs; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      check("req_accept_timeout", n, 0);
    end else begin
      @(posedge clk);
      cur_addr = a; cur_we = we; cur_wdata = d;
      if (!rs && !we) begin
        rd_q.push_back(rd);
        model_rdata = rd;
      end
      exp_q.push_back(model_rdata);
      @(negedge clk);
    end
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_reset = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("rsp_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_seq_check();
    int n = 0;
    bit early_ready = 1'b0;
    rst_n = 1'b1;
    while (!cia_res_n && n < 400) begin
      @(negedge clk);
      n++;
      if (!cia_res_n && req_ready) early_ready = 1'b1;
    end
    check("res_n_low_clks", n, RES_CYCLES * 2 * PHI2_DIV);
    check("res_n_rise_on_phi2_fall", {prev_phi2, phi2}, 2'b10);
    check("ready_during_reset", early_ready, 1'b0);
    check("ready_after_reset", req_ready, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("reset_outputs",
          {phi2, cia_res_n, cs_n, r_w_n, addr, data_o, data_oe, rsp_valid, rsp_rdata, req_ready, irq},
          {1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    reset_seq_check();

    do_req(1'b0, 1'b1, 4'h3, 8'h5A, 8'h00); idle_req(); wait_done();
    do_req(1'b0, 1'b0, 4'h0, 8'h00, 8'hA5); idle_req(); wait_done();
    check("read_result", rsp_rdata, 8'hA5);

    last_rise_t = 0; b2b = 1'b1;
    do_req(1'b0, 1'b0, 4'h0, 8'h00, 8'h3C);
    do_req(1'b0, 1'b0, 4'h1, 8'h00, 8'hC3);
    idle_req(); wait_done();
    b2b = 1'b0;

    for (int i = 0; i < 4; i++) begin
      logic we;
      we = 1'($urandom_range(0, 1));
      do_req(1'b0, we, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)));
      idle_req(); wait_done();
    end

    do_req(1'b1, 1'b0, 4'h0, 8'h00, 8'h00); idle_req();
    check("req_reset_res_n_low", cia_res_n, 1'b0);
    check("req_reset_not_ready", req_ready, 1'b0);
    wait_done();
    check("req_reset_done_res_n", cia_res_n, 1'b1);

`ifdef CIA_BUS_MASTER_IRQ_EN
    begin
      int n;
      irq_n = 1'b0; n = 0;
      while (!irq && n < 3) begin @(negedge clk); n++; end
      check("irq_set", irq, 1'b1);
      do_req(1'b0, 1'b0, 4'hD, 8'h00, 8'h81); idle_req(); wait_done();
      check("irq_cleared_by_icr_read", irq, 1'b0);
      repeat (10) @(negedge clk);
      check("irq_no_reset_while_low", irq, 1'b0);
      irq_n = 1'b1; repeat (5) @(negedge clk);
      irq_n = 1'b0; n = 0;
      while (!irq && n < 3) begin @(negedge clk); n++; end
      check("irq_set_again", irq, 1'b1);
      irq_n = 1'b1;
    end
`else
    irq_n = 1'b0; repeat (5) @(negedge clk);
    check("irq_disabled", irq, 1'b0);
    irq_n = 1'b1;
`endif

    // Abort a write in PH2 with rst_n.
    begin
      int n = 0;
      do_req(1'b0, 1'b1, 4'h5, 8'h77, 8'h00); idle_req();
      while (!data_oe && n < 200) begin @(negedge clk); n++; end
      check("ph2_reached", data_oe, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_cs_n", cs_n, 1'b1);
      check("abort_data_oe", data_oe, 1'b0);
      check("abort_no_rsp", rsp_valid, 1'b0);
      exp_q.delete(); rd_q.delete();
      model_rdata = 8'h00;
      @(negedge clk);
      reset_seq_check();
    end

    do_req(1'b0, 1'b0, 4'h2, 8'h00, 8'h96); idle_req(); wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
